// File: rtl/echo_display_pkg.sv
// Shared symbol codes, widths and seven-segment patterns for the echo display blocks.
package echo_display_pkg;

    localparam int CODE_W = 5;
    localparam int SEG_W  = 7;

    typedef logic [CODE_W-1:0] sym_t;
    typedef logic [SEG_W-1:0]  seg_t;

    localparam sym_t SYM_BLANK = 5'd16;
    localparam sym_t SYM_DASH  = 5'd17;

    // Segment order is a..g from bit 6 down to bit 0, active-high.
    localparam seg_t SEG_0     = 7'h7E;
    localparam seg_t SEG_1     = 7'h30;
    localparam seg_t SEG_2     = 7'h6D;
    localparam seg_t SEG_3     = 7'h79;
    localparam seg_t SEG_4     = 7'h33;
    localparam seg_t SEG_5     = 7'h5B;
    localparam seg_t SEG_6     = 7'h5F;
    localparam seg_t SEG_7     = 7'h70;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h7B;
    localparam seg_t SEG_A     = 7'h77;
    localparam seg_t SEG_B     = 7'h1F;
    localparam seg_t SEG_C     = 7'h4E;
    localparam seg_t SEG_D     = 7'h3D;
    localparam seg_t SEG_E     = 7'h4F;
    localparam seg_t SEG_F     = 7'h47;
    localparam seg_t SEG_BLANK = 7'h00;
    localparam seg_t SEG_DASH  = 7'h01;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/echo_display_mux_if.sv
// Write port and display pins of echo_display_mux; master = producer/board side, slave = driver.
interface echo_display_mux_if
    import echo_display_pkg::*;
#(
    parameter int DIGITS = 4
);

    logic                     wr_valid;
    logic                     wr_ready;
    logic [CODE_W*DIGITS-1:0] wr_data;
    logic [DIGITS-1:0]        blink_mask;
    seg_t                     seg;
    logic [DIGITS-1:0]        an;
    logic                     frame_start;

    modport master (
        output wr_valid,
        output wr_data,
        output blink_mask,
        input  wr_ready,
        input  seg,
        input  an,
        input  frame_start
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  blink_mask,
        output wr_ready,
        output seg,
        output an,
        output frame_start
    );

endinterface

// File: rtl/echo_seg_decode.sv
// Combinational symbol-code to seven-segment decoder (a..g, active-high).
module echo_seg_decode
    import echo_display_pkg::*;
(
    input  sym_t code,
    output seg_t seg
);

    // Codes 18..31 and anything unexpected fall through to blank.
    always_comb begin
        seg = SEG_BLANK;
        case (code)
            5'd0:      seg = SEG_0;
            5'd1:      seg = SEG_1;
            5'd2:      seg = SEG_2;
            5'd3:      seg = SEG_3;
            5'd4:      seg = SEG_4;
            5'd5:      seg = SEG_5;
            5'd6:      seg = SEG_6;
            5'd7:      seg = SEG_7;
            5'd8:      seg = SEG_8;
            5'd9:      seg = SEG_9;
            5'd10:     seg = SEG_A;
            5'd11:     seg = SEG_B;
            5'd12:     seg = SEG_C;
            5'd13:     seg = SEG_D;
            5'd14:     seg = SEG_E;
            5'd15:     seg = SEG_F;
            SYM_BLANK: seg = SEG_BLANK;
            SYM_DASH:  seg = SEG_DASH;
            default:   seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/echo_display_mux.sv
// Multiplexed seven-segment driver with frame-aligned double buffering.
// Optional blink support is compiled in with ECHO_DISPLAY_BLINK_EN.
module echo_display_mux
    import echo_display_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    echo_display_mux_if.slave  bus
);

    localparam int IDX_W = clog2_min1(DIGITS);
    localparam int PRE_W = clog2_min1(PRESCALE);

    localparam logic [IDX_W-1:0]  IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [PRE_W-1:0]  PRE_ZERO = {PRE_W{1'b0}};
    localparam logic [PRE_W-1:0]  PRE_ONE  = PRE_W'(1);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [DIGITS-1:0] AN_ONE   = DIGITS'(1);

    logic [PRE_W-1:0]             presc_r;
    logic [IDX_W-1:0]             idx_r;
    logic [IDX_W-1:0]             idx_nxt_s;
    logic                         tick_s;
    logic                         boundary_s;
    logic                         accept_s;

    logic [DIGITS-1:0][CODE_W-1:0] active_r;
    logic [DIGITS-1:0][CODE_W-1:0] pending_r;
    logic                          pend_full_r;

    sym_t                         cur_code_s;
    seg_t                         dec_seg_s;
    logic                         blank_digit_s;
    seg_t                         seg_nxt_s;
    logic [DIGITS-1:0]            an_nxt_s;
    logic                         frame_start_nxt_s;

    seg_t                         seg_r;
    logic [DIGITS-1:0]            an_r;
    logic                         frame_start_r;

    assign tick_s       = (presc_r == PRE_LAST);
    assign boundary_s   = tick_s && (idx_r == IDX_LAST);
    assign accept_s     = bus.wr_valid && !pend_full_r;
    assign bus.wr_ready = !pend_full_r;

    // Prescaler: free-running 0..PRESCALE-1, tick on the last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= PRE_ZERO;
        end else if (tick_s) begin
            presc_r <= PRE_ZERO;
        end else begin
            presc_r <= presc_r + PRE_ONE;
        end
    end

    // Scan state register: the digit index is the whole FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= IDX_ZERO;
        end else begin
            idx_r <= idx_nxt_s;
        end
    end

    // Scan next-state: advance one digit per tick, wrapping after the last digit.
    always_comb begin
        idx_nxt_s = idx_r;
        if (tick_s) begin
            if (idx_r == IDX_LAST) begin
                idx_nxt_s = IDX_ZERO;
            end else begin
                idx_nxt_s = idx_r + IDX_ONE;
            end
        end else begin
            idx_nxt_s = idx_r;
        end
    end

    // Write buffer and frame-boundary swap; accept and drain never coincide
    // because a write is only accepted while pending is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r    <= {DIGITS{SYM_BLANK}};
            pending_r   <= {DIGITS{SYM_BLANK}};
            pend_full_r <= 1'b0;
        end else if (accept_s) begin
            pending_r   <= bus.wr_data;
            pend_full_r <= 1'b1;
        end else if (boundary_s && pend_full_r) begin
            active_r    <= pending_r;
            pend_full_r <= 1'b0;
        end else begin
            pend_full_r <= pend_full_r;
        end
    end

`ifdef ECHO_DISPLAY_BLINK_EN
    localparam int               FRM_W    = clog2_min1(BLINK_FRAMES);
    localparam logic [FRM_W-1:0] FRM_ZERO = {FRM_W{1'b0}};
    localparam logic [FRM_W-1:0] FRM_ONE  = FRM_W'(1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [FRM_W-1:0] frame_cnt_r;
    logic             blink_phase_r;

    // Blink timing: count frame boundaries, flip phase every BLINK_FRAMES frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r   <= FRM_ZERO;
            blink_phase_r <= 1'b0;
        end else if (boundary_s) begin
            if (frame_cnt_r == FRM_LAST) begin
                frame_cnt_r   <= FRM_ZERO;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                frame_cnt_r   <= frame_cnt_r + FRM_ONE;
            end
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign blank_digit_s = blink_phase_r & bus.blink_mask[idx_r];
`else
    logic blink_unused_s;

    assign blink_unused_s = ^{bus.blink_mask, 32'(BLINK_FRAMES)};
    assign blank_digit_s  = 1'b0;
`endif

    assign cur_code_s = active_r[idx_r];

    echo_seg_decode u_seg_decode (
        .code (cur_code_s),
        .seg  (dec_seg_s)
    );

    // Scan outputs: decoded segments, one-hot enable, frame marker for digit 0.
    always_comb begin
        seg_nxt_s         = dec_seg_s;
        an_nxt_s          = AN_ONE << idx_r;
        frame_start_nxt_s = (idx_r == IDX_ZERO) && (presc_r == PRE_ZERO);
        if (blank_digit_s) begin
            seg_nxt_s = SEG_BLANK;
        end else begin
            seg_nxt_s = dec_seg_s;
        end
    end

    // Output registers; pins follow the scan state by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r         <= SEG_BLANK;
            an_r          <= {DIGITS{1'b0}};
            frame_start_r <= 1'b0;
        end else begin
            seg_r         <= seg_nxt_s;
            an_r          <= an_nxt_s;
            frame_start_r <= frame_start_nxt_s;
        end
    end

    assign bus.seg         = seg_r;
    assign bus.an          = an_r;
    assign bus.frame_start = frame_start_r;

endmodule

// File: tb/tb_echo_display_mux.sv
// Directed self-checking bench for echo_display_mux (DIGITS=4, PRESCALE=4, BLINK_FRAMES=2).
module tb_echo_display_mux;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    logic [6:0] g_seg [4];
    logic [3:0] g_an  [4];
    logic [6:0] exp_seg [4];

    echo_display_mux_if #(.DIGITS(4)) bus_if ();

    echo_display_mux #(
        .DIGITS       (4),
        .PRESCALE     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bounded wait for the next cycle showing frame_start.
    task automatic sync_fs();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus_if.frame_start === 1'b1) got = 1'b1;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL sync_fs: frame_start not seen within 40 cycles, required a pulse");
        end
    endtask

    // Called in a frame_start cycle; records seg/an mid-slot for each digit, ends on slot 15.
    task automatic grab_frame();
        for (int k = 0; k < 16; k++) begin
            if (k % 4 == 2) begin
                g_seg[k/4] = bus_if.seg;
                g_an[k/4]  = bus_if.an;
            end
            if (k < 15) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n             = 1'b0;
        bus_if.wr_valid   = 1'b0;
        bus_if.wr_data    = 20'd0;
        bus_if.blink_mask = 4'b0000;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus_if.seg !== 7'h00) begin n_fail++; $display("FAIL reset_seg got %h exp 00", bus_if.seg); end
        n_tests++;
        if (bus_if.an !== 4'b0000) begin n_fail++; $display("FAIL reset_an got %b exp 0000", bus_if.an); end
        n_tests++;
        if (bus_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got %b exp 1", bus_if.wr_ready); end
        n_tests++;
        if (bus_if.frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs got %b exp 0", bus_if.frame_start); end
        rst_n = 1'b1;
        sync_fs();
        for (int k = 0; k < 16; k++) begin
            n_tests++;
            if (bus_if.an !== (4'b0001 << (k / 4))) begin
                n_fail++; $display("FAIL scan_an cycle %0d got %b exp %b", k, bus_if.an, 4'b0001 << (k / 4));
            end
            n_tests++;
            if (bus_if.seg !== 7'h00) begin n_fail++; $display("FAIL scan_seg cycle %0d got %h exp 00", k, bus_if.seg); end
            n_tests++;
            if (bus_if.frame_start !== (k == 0)) begin
                n_fail++; $display("FAIL scan_fs cycle %0d got %b exp %b", k, bus_if.frame_start, (k == 0));
            end
            @(negedge clk);
        end
        n_tests++;
        if (bus_if.frame_start !== 1'b1) begin n_fail++; $display("FAIL scan_period fs got %b exp 1", bus_if.frame_start); end
    endtask

    task automatic test_write_display();
        sync_fs();
        repeat (5) @(negedge clk);
        bus_if.wr_data  = {5'd3, 5'd2, 5'd1, 5'd0};
        bus_if.wr_valid = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus_if.wr_ready !== 1'b0) begin n_fail++; $display("FAIL wr_ready_drop got %b exp 0", bus_if.wr_ready); end
        n_tests++;
        if (bus_if.seg !== 7'h00) begin n_fail++; $display("FAIL no_mid_frame_update got %h exp 00", bus_if.seg); end
        bus_if.wr_valid = 1'b0;
        bus_if.wr_data  = 20'hFFFFF;
        repeat (8) @(negedge clk);
        n_tests++;
        if (bus_if.wr_ready !== 1'b0) begin n_fail++; $display("FAIL wr_ready_boundary got %b exp 0", bus_if.wr_ready); end
        @(negedge clk);
        n_tests++;
        if (bus_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_rise got %b exp 1", bus_if.wr_ready); end
        @(negedge clk);
        n_tests++;
        if (bus_if.frame_start !== 1'b1) begin n_fail++; $display("FAIL write_fs got %b exp 1", bus_if.frame_start); end
        grab_frame();
        exp_seg = '{7'h7E, 7'h30, 7'h6D, 7'h79};
        for (int d = 0; d < 4; d++) begin
            n_tests++;
            if (g_seg[d] !== exp_seg[d]) begin n_fail++; $display("FAIL write_d%0d seg got %h exp %h", d, g_seg[d], exp_seg[d]); end
            n_tests++;
            if (g_an[d] !== (4'b0001 << d)) begin n_fail++; $display("FAIL write_d%0d an got %b exp %b", d, g_an[d], 4'b0001 << d); end
        end
    endtask

    task automatic test_back_pressure();
        sync_fs();
        repeat (2) @(negedge clk);
        bus_if.wr_data  = {4{5'd5}};
        bus_if.wr_valid = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus_if.wr_ready !== 1'b0) begin n_fail++; $display("FAIL bp_first_accept got %b exp 0", bus_if.wr_ready); end
        bus_if.wr_data = {4{5'd17}};
        repeat (11) @(negedge clk);
        n_tests++;
        if (bus_if.wr_ready !== 1'b0) begin n_fail++; $display("FAIL bp_held got %b exp 0", bus_if.wr_ready); end
        @(negedge clk);
        n_tests++;
        if (bus_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise got %b exp 1", bus_if.wr_ready); end
        @(negedge clk);
        n_tests++;
        if (bus_if.wr_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_accept got %b exp 0", bus_if.wr_ready); end
        n_tests++;
        if (bus_if.frame_start !== 1'b1) begin n_fail++; $display("FAIL bp_fs got %b exp 1", bus_if.frame_start); end
        bus_if.wr_valid = 1'b0;
        grab_frame();
        for (int d = 0; d < 4; d++) begin
            n_tests++;
            if (g_seg[d] !== 7'h5B) begin n_fail++; $display("FAIL bp_first_d%0d got %h exp 5b", d, g_seg[d]); end
        end
        @(negedge clk);
        n_tests++;
        if (bus_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL bp_drained got %b exp 1", bus_if.wr_ready); end
        grab_frame();
        for (int d = 0; d < 4; d++) begin
            n_tests++;
            if (g_seg[d] !== 7'h01) begin n_fail++; $display("FAIL bp_dash_d%0d got %h exp 01", d, g_seg[d]); end
        end
    endtask

    task automatic test_boundary_collision();
        sync_fs();
        repeat (14) @(negedge clk);
        n_tests++;
        if (bus_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL coll_ready got %b exp 1", bus_if.wr_ready); end
        bus_if.wr_data  = {5'd15, 5'd14, 5'd13, 5'd12};
        bus_if.wr_valid = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus_if.wr_ready !== 1'b0) begin n_fail++; $display("FAIL coll_accept got %b exp 0", bus_if.wr_ready); end
        bus_if.wr_valid = 1'b0;
        @(negedge clk);
        grab_frame();
        for (int d = 0; d < 4; d++) begin
            n_tests++;
            if (g_seg[d] !== 7'h01) begin n_fail++; $display("FAIL coll_no_bypass_d%0d got %h exp 01", d, g_seg[d]); end
        end
        @(negedge clk);
        grab_frame();
        exp_seg = '{7'h4E, 7'h3D, 7'h4F, 7'h47};
        for (int d = 0; d < 4; d++) begin
            n_tests++;
            if (g_seg[d] !== exp_seg[d]) begin n_fail++; $display("FAIL coll_late_d%0d got %h exp %h", d, g_seg[d], exp_seg[d]); end
        end
    endtask

    task automatic test_blink();
        logic [6:0] exp_d0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        bus_if.blink_mask = 4'b0001;
        rst_n = 1'b1;
        sync_fs();
        @(negedge clk);
        bus_if.wr_data  = {5'd3, 5'd2, 5'd1, 5'd8};
        bus_if.wr_valid = 1'b1;
        @(negedge clk);
        bus_if.wr_valid = 1'b0;
        repeat (13) @(negedge clk);
        for (int f = 0; f < 5; f++) begin
            @(negedge clk);
            n_tests++;
            if (bus_if.frame_start !== 1'b1) begin n_fail++; $display("FAIL blink_fs frame %0d got %b exp 1", f, bus_if.frame_start); end
            grab_frame();
`ifdef ECHO_DISPLAY_BLINK_EN
            exp_d0 = (f == 1 || f == 2) ? 7'h00 : 7'h7F;
`else
            exp_d0 = 7'h7F;
`endif
            n_tests++;
            if (g_seg[0] !== exp_d0) begin n_fail++; $display("FAIL blink_d0 frame %0d got %h exp %h", f, g_seg[0], exp_d0); end
            n_tests++;
            if (g_seg[1] !== 7'h30) begin n_fail++; $display("FAIL blink_d1 frame %0d got %h exp 30", f, g_seg[1]); end
            n_tests++;
            if (g_seg[3] !== 7'h79) begin n_fail++; $display("FAIL blink_d3 frame %0d got %h exp 79", f, g_seg[3]); end
            n_tests++;
            if (g_an[0] !== 4'b0001) begin n_fail++; $display("FAIL blink_an frame %0d got %b exp 0001", f, g_an[0]); end
        end
        bus_if.blink_mask = 4'b0000;
    endtask

    task automatic test_midframe_reset();
        sync_fs();
        @(negedge clk);
        bus_if.wr_data  = {4{5'd9}};
        bus_if.wr_valid = 1'b1;
        @(negedge clk);
        bus_if.wr_valid = 1'b0;
        n_tests++;
        if (bus_if.wr_ready !== 1'b0) begin n_fail++; $display("FAIL mr_pending got %b exp 0", bus_if.wr_ready); end
        repeat (7) @(negedge clk);
        n_tests++;
        if (bus_if.an !== 4'b0100) begin n_fail++; $display("FAIL mr_position an got %b exp 0100", bus_if.an); end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus_if.seg !== 7'h00) begin n_fail++; $display("FAIL mr_seg got %h exp 00", bus_if.seg); end
        n_tests++;
        if (bus_if.an !== 4'b0000) begin n_fail++; $display("FAIL mr_an got %b exp 0000", bus_if.an); end
        n_tests++;
        if (bus_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL mr_ready got %b exp 1", bus_if.wr_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sync_fs();
        grab_frame();
        for (int d = 0; d < 4; d++) begin
            n_tests++;
            if (g_seg[d] !== 7'h00) begin n_fail++; $display("FAIL mr_blank1_d%0d got %h exp 00", d, g_seg[d]); end
            n_tests++;
            if (g_an[d] !== (4'b0001 << d)) begin n_fail++; $display("FAIL mr_an_d%0d got %b exp %b", d, g_an[d], 4'b0001 << d); end
        end
        @(negedge clk);
        grab_frame();
        for (int d = 0; d < 4; d++) begin
            n_tests++;
            if (g_seg[d] !== 7'h00) begin n_fail++; $display("FAIL mr_blank2_d%0d got %h exp 00", d, g_seg[d]); end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_write_display();
        test_back_pressure();
        test_boundary_collision();
        test_blink();
        test_midframe_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/echo_display_mux.md
# echo_display_mux

Multiplexed multi-digit seven-segment driver: the parametrised successor to the single-digit echo display decoder. It takes one 5-bit symbol code per digit through a valid/ready write port, double-buffers it, and time-multiplexes the digits onto one shared a–g segment bus with one-hot digit enables. New digit data is applied only at frame boundaries, so a frame never shows a mix of old and new data. It sits between the echo encoder/controller logic and the board's display pins.

## Interface
- `DIGITS`, default 4: number of multiplexed digits (2..8).
- `PRESCALE`, default 1000: clock cycles each digit is lit (≥2).
- `BLINK_FRAMES`, default 64: frames per blink half-period (≥1); used only with blink compiled in.
- `clk`  in  1  system clock, all state on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_valid`  in  1  a write is offered on `wr_data`.
- `wr_ready`  out  1  the pending buffer is free.
- `wr_data`  in  5*DIGITS  symbol codes; digit i occupies bits [5i+4:5i].
- `blink_mask`  in  DIGITS  per-digit blink enable.
- `seg`  out  7  segments, bit6=a … bit0=g, active-high.
- `an`  out  DIGITS  one-hot digit enable, active-high.
- `frame_start`  out  1  one-cycle pulse in the cycle `an` selects digit 0.

## Operation
- Symbol codes (hex, a..g):
  - 0–9: 7E, 30, 6D, 79, 33, 5B, 5F, 70, 7F, 7B.
  - A–F (10–15): 77, 1F, 4E, 3D, 4F, 47.
  - 16: blank (00). 17: '-' (01). 18–31: blank.
- Two buffers: `active` (displayed) and `pending`, plus a `pend_full` flag.
- Write handshake:
  - `wr_ready = ~pend_full`.
  - When `wr_valid & wr_ready`: `wr_data` goes into `pending` and `pend_full` is set.
  - `wr_data` is sampled only in the accept cycle.
- Prescaler counts 0..PRESCALE-1. `tick` is asserted at PRESCALE-1, and the count wraps to 0.
- Digit index `idx` advances on `tick` and wraps from DIGITS-1 to 0.
- Frame boundary = `tick` while `idx==DIGITS-1`.
  - If `pend_full` is set at the boundary: `pending` is copied to `active` and `pend_full` clears.
  - If a write is accepted in the same cycle as a boundary, it stays pending until the next boundary. There is no bypass.
- Digit FSM: SCAN only; `idx` is the state. No idle state; scanning runs continuously after reset.
- Reset mid-operation: everything returns to reset values immediately, and any pending write is discarded.

## Timing
- Reset values:
  - `seg=0`, `an=0`, `frame_start=0`, `wr_ready=1` (comb. from `pend_full=0`).
  - `idx=0`, prescaler 0, `active` all code 16 (blank), blink phase 0.
- `seg`/`an`/`frame_start` are registered.
  - First edge after reset release: `an=1<<0`, `frame_start=1`, `seg`=decode of active digit 0.
  - `an` changes on the edge after each `tick`. Each digit is lit for exactly PRESCALE cycles, and a frame lasts DIGITS×PRESCALE cycles.
- Data latency: an accepted write is displayed starting with the first frame after the next boundary, i.e. within at most 2 frames.
- `wr_ready` rises in the cycle after the boundary that drains `pending`.

## Configuration
- `ECHO_DISPLAY_BLINK_EN` defined:
  - Frame counter counts 0..BLINK_FRAMES-1 on boundaries; blink phase toggles when it wraps.
  - While phase=1, digits with `blink_mask[i]=1` output `seg=0`. `an` keeps scanning.
- Undefined: the `blink_mask` port still exists but is ignored, and no blink counter is synthesised.

## Structure
- Shared package `echo_display_pkg`:
  - symbol code constants (`SYM_BLANK=16`, `SYM_DASH=17`);
  - code width 5 and segment width 7;
  - seven-segment pattern constants.
- One sub-module, `echo_seg_decode`: combinational 5-bit code → 7-bit segment pattern. The top level muxes the `active` digit at `idx` into it and registers the result.

## Test plan
(Benches use DIGITS=4, PRESCALE=4, BLINK_FRAMES=2 unless noted.)
- Reset/scan:
  - during `rst_n` low: `seg=0`, `an=0`, `wr_ready=1`;
  - after release: `an` = 0001, 0010, 0100, 1000, each for 4 cycles;
  - `seg=00` throughout; `frame_start` pulses every 16 cycles.
- Write/display: write codes {3,2,1,0} mid-frame.
  - `wr_ready` drops the next cycle.
  - After the boundary, digit0 shows 7E, digit1 30, digit2 6D, digit3 79.
  - `wr_ready` returns to 1.
- Back-pressure: a second write of {17,17,17,17} held valid while pending.
  - It is not accepted until `wr_ready` rises.
  - Following frames show 01 on all digits.
- Boundary collision: a write accepted exactly on a boundary cycle is not displayed in the next frame; it appears one frame later.
- Blink (macro on): `blink_mask=0001` with digit0=8.
  - Digit0 `seg` alternates 7F for 2 frames, then 00 for 2 frames.
  - Other digits are unaffected.
  - With the macro off, digit0 stays 7F.
- Mid-frame reset: assert `rst_n` while `an=0100` with a write pending.
  - `seg`/`an` go to 0 immediately.
  - After release, scanning restarts at 0001, all digits blank, and the pending data is lost.
